alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Shares the single registered ALU between NUM_REQ requesters, such as decode slots or an address-generation unit, using a round-robin policy. It accepts one operation at a time through a valid/ready handshake and drives the ALU operand and op lines. It captures the ALU result after the ALU's one-cycle registered latency and returns it to the originating requester through a held valid/ready response. The block sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
XLEN, 32, operand and result width.
OPW, 4, ALU op width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-high reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_ready  out  NUM_REQ  one-hot grant; handshake occurs when valid and ready are both high.
req_rs1  in  NUM_REQ*XLEN  flattened operand A; requester i occupies bits [i*XLEN +: XLEN].
req_rs2  in  NUM_REQ*XLEN  flattened operand B.
req_op  in  NUM_REQ*OPW  flattened ALU op code.
resp_valid  out  NUM_REQ  one-hot response valid.
resp_ready  in  NUM_REQ  per-requester response accept.
resp_data  out  XLEN  result for the requester whose resp_valid bit is set.
alu_rs1  out  XLEN  to ALU rs1.
alu_rs2  out  XLEN  to ALU rs2.
alu_op  out  OPW  to ALU ALUop.
alu_result  in  XLEN  from ALU result (registered inside the ALU, 1-cycle latency).
busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is the combinational one-hot round-robin pick among set req_valid bits. The search starts at rr_ptr and wraps modulo NUM_REQ.
  - req_ready is 0 when no req_valid bit is set.
  - On a handshake at edge E0: latch grant index, rs1, rs2 and op; set rr_ptr = (grant+1) mod NUM_REQ; go to ISSUE.
- ISSUE: alu_rs1/alu_rs2/alu_op drive the latched values. The ALU samples them at edge E1; go to WAIT.
- WAIT: operands stay held; alu_result is valid. At edge E2, capture alu_result into resp_data; go to RESP.
- RESP:
  - resp_valid[grant] = 1; resp_data is held stable.
  - When resp_ready[grant] = 1 at an edge: go to IDLE.
  - resp_ready bits of other requesters are ignored.
- req_ready is 0 in ISSUE, WAIT and RESP.
- Latency and throughput: accept at E0, resp_valid visible after E2. The earliest next accept is the edge after the response is consumed, so a saturated requester gets one op per 4 cycles.
- alu_op outside ISSUE/WAIT is OP_NOP (4'b1111), which the ALU resolves to 0. alu_rs1/alu_rs2 are 0 outside ISSUE/WAIT.
- Op codes pass through unchecked. Unknown codes yield whatever the ALU returns (0 by default).
- Reset, and its values:
  - State goes to IDLE, rr_ptr = 0, grant = 0.
  - resp_valid = 0, resp_data = 0, req_ready = 0 during the reset cycle, alu_* = 0 / OP_NOP, busy = 0.
- Reset mid-operation (ISSUE/WAIT/RESP): the in-flight op is dropped with no response. The requester must re-issue.
- A requester may deassert req_valid before a handshake without error.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that keeps its request valid is served within NUM_REQ grants.
- Width rule: all data paths are XLEN-bit, with no truncation or extension.

Decomposition:
- Shared package alu_pkg:
  - OP_ADD=4'b1001, OP_SUB=4'b0001, OP_XOR=4'b0010, OP_OR=4'b0011, OP_AND=4'b0100, OP_SLL=4'b0101, OP_SRL=4'b1101, OP_NOP=4'b1111.
  - FSM state encoding.
- Sub-module rr_pick (NUM_REQ): inputs req vector and pointer; output is the one-hot grant. It is purely combinational and reused by other arbiters.

Test Plan:
The bench instantiates the real ALU behind alu_arbiter.
1. After reset, req0 issues OP_ADD with rs1=12, rs2=18, resp_ready=1 → req_ready[0]=1 in the same cycle; resp_valid=2'b01 two edges after the accept; resp_data=30; busy falls after the response is consumed.
2. Both requesters valid in the same cycle, req0 with OP_SUB 18,12 and req1 with OP_XOR 18,12 → req0 is granted first (resp 6), then req1 (resp 30). A second simultaneous pair is granted req0 then req1 again (rr_ptr returns to 0).
3. req1 issues OP_SLL 18,2 with resp_ready low for 5 cycles → resp_data holds 72 with resp_valid[1] held; req_ready stays 0 while req0 is pending. req0 (OP_AND 18,12) is accepted only after the response handshake, and returns 0.
4. OP_SRL 18,2 → 4. OP_OR 18,12 → 30. Op 4'b1111 with 18,12 → 0.
5. rst asserted for one cycle during WAIT of an OP_ADD → no resp_valid appears; alu_op=OP_NOP and rr_ptr=0 after reset; the next OP_ADD 12,18 returns 30 normally.
6. req0 continuously valid with 10 OP_ADD ops and resp_ready=1 → an accept every 4 cycles; 10 responses arrive in order with the correct sums; req1 idle never receives resp_valid.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op codes and arbiter FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b1101;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: flattened per-requester request
// lanes plus a one-hot held response.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is a one-hot grant; resp_valid is one-hot and stays
// high with resp_data stable until resp_ready of that same requester is high.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int OPW     = 4
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*XLEN-1:0] req_rs1;
  logic [NUM_REQ*XLEN-1:0] req_rs2;
  logic [NUM_REQ*OPW-1:0]  req_op;
  logic [NUM_REQ-1:0]      resp_valid;
  logic [NUM_REQ-1:0]      resp_ready;
  logic [XLEN-1:0]         resp_data;

  // Requesters drive the request lanes and accept responses.
  modport master (
    output req_valid, req_rs1, req_rs2, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  // The arbiter grants requests and returns results.
  modport slave (
    input  req_valid, req_rs1, req_rs2, req_op, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first set request
// bit found searching upward from ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt
);

  // Scan NUM_REQ positions starting at ptr; the first hit wins.
  always_comb begin : pick_proc
    int          s;
    logic        found;
    logic [PW-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    s     = 0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = PW'(s);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end for a single registered ALU. One operation is in
// flight at a time: accept (IDLE) -> drive ALU (ISSUE) -> ALU result valid
// (WAIT) -> hold response until the owner accepts it (RESP).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int OPW     = 4
) (
  input  logic            clk,
  input  logic            rst,
  alu_arbiter_if.slave    bus,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [OPW-1:0]  alu_op,
  input  logic [XLEN-1:0] alu_result,
  output logic            busy,
  output state_e          state_o
);

  localparam int PW = $clog2(NUM_REQ);

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;

  logic [NUM_REQ-1:0] pick;

  rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick)
  );

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      op_q        <= OPW'(OP_NOP);
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      op_q        <= op_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Next-state logic: latch the granted lane on accept, capture the ALU
  // result in WAIT, release on the owner's resp_ready.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    op_d        = op_q;
    resp_data_d = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (|(bus.req_valid & bus.req_ready)) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
              grant_d  = PW'(i);
              rs1_d    = bus.req_rs1[i*XLEN +: XLEN];
              rs2_d    = bus.req_rs2[i*XLEN +: XLEN];
              op_d     = bus.req_op[i*OPW +: OPW];
              rr_ptr_d = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
            end
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        resp_data_d = alu_result;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready[grant_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state: grant only in IDLE outside reset, ALU lines
  // parked at zero/NOP unless an operation is being executed.
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE && !rst) ? pick : '0;
    bus.resp_data  = resp_data_q;
    bus.resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.resp_valid[i] = (state_q == S_RESP) && (grant_q == PW'(i));
    end
    if (state_q == S_ISSUE || state_q == S_WAIT) begin
      alu_rs1 = rs1_q;
      alu_rs2 = rs2_q;
      alu_op  = op_q;
    end else begin
      alu_rs1 = '0;
      alu_rs2 = '0;
      alu_op  = OPW'(OP_NOP);
    end
    busy    = (state_q != S_IDLE);
    state_o = state_q;
  end

endmodule
